rnn_mem_responder: RTL and testbench
====================================

Name: rnn_mem_responder

Overview:
- Environment-side counterpart of the RNN core's memory and input interface.
- Holds the parameter banks (W_ih, b_ih, W_hh, b_hh, sequence length), the per-timestep 32-bit input vectors and the result bank.
- Answers the core's mce/msel/maddr reads with mdata_r and captures its mdata_w result writes.
- Drives ready/idata under a start/done handshake from a host loader. Used in the system testbench and the FPGA wrapper.

Parameters:
- DW, 20, memory data width (Q4.16 signed).
- HID, 64, hidden size.
- IN_W, 32, input vector width.
- T_MAX, 16, maximum timesteps stored (result bank depth T_MAX*HID, input bank depth T_MAX).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- busy  in  1  core busy
- ready  out  1  start request to core
- i_en  in  1  core requests next input vector
- idata  out  32  current input vector
- mce  in  1  core memory enable
- msel  in  3  bank select: 0 W_ih, 1 b_ih, 2 W_hh, 3 b_hh, 4 T, 5 result (write)
- maddr  in  17  bank address; bank 5 is {t[10:0],h[5:0]}
- mdata_r  out  20  read data
- mdata_w  in  20  write data
- ld_valid  in  1  host load strobe
- ld_sel  in  3  load bank: 0-4 as msel, 6 input bank
- ld_addr  in  17  load address
- ld_data  in  32  load data; banks 0-4 use [19:0]
- start  in  1  host start pulse
- done  out  1  one-cycle completion pulse
- err  out  1  sticky protocol-error flag
- rd_addr  in  17  result readback address
- rd_data  out  20  result readback data (registered, 1-cycle latency)

Behaviour:
- Reset (reset=0, async): ready=0, done=0, err=0, idata=0, mdata_r=0, rd_data=0; FSM to IDLE; input pointer ip=0; result bank contents not cleared.
- FSM IDLE -> ARM on start. ARM drives ready=1 until busy=1 is sampled, then RUN with ready=0. RUN -> FIN when busy falls. FIN pulses done for 1 cycle -> IDLE.
- start outside IDLE is ignored and sets err.
- Reads:
  - mdata_r is combinational from msel/maddr when mce=1 and msel is 0-4; otherwise it holds its last value.
  - W_ih index maddr[10:0] (h*32+i).
  - W_hh index maddr[11:0] (h*64+j).
  - b_ih/b_hh index maddr[5:0].
  - msel=4 returns T, the sequence length, at any address.
- Write: mce=1 and msel=5 writes mdata_w to result[{maddr[16:6],maddr[5:0]}] at posedge.
  - t = maddr[16:6] >= T_MAX drops the write and sets err.
  - msel 6/7 with mce=1 sets err.
- Input: each cycle with i_en=1, idata <= input[ip] registered and ip <= ip+1. idata is held between requests.
  - i_en with ip >= T or ip >= T_MAX sets err and drives idata=0.
  - ip resets to 0 on entry to ARM.
- Loader: ld_valid writes any bank at posedge. Accepted only in IDLE; otherwise dropped and err set. Out-of-range addresses are dropped and set err.
- Readback: rd_data <= result[rd_addr] every cycle, usable in any state.
- Simultaneous ld_valid and start in IDLE: the load completes and the FSM moves to ARM.
- Reset mid-RUN returns the FSM to IDLE immediately. Results already written are kept.

Optional Feature:
- RNN_RESP_STATS_EN defined:
  - Adds 16-bit saturating counters per bank 0-5 counting mce accesses and a 16-bit i_en counter, all cleared on ARM entry.
  - Exposed on extra output stat_bus[111:0] ({ien,b5..b0}).
- Undefined: no counters and no stat_bus port.

Decomposition:
- Shared package rnn_pkg:
  - msel bank encodings (MSEL_WIH=0 … MSEL_OUT=5, LD_INPUT=6).
  - DW, HID, IN_W constants.
  - FSM state enum {IDLE, ARM, RUN, FIN}.
- One natural sub-module rnn_bank_ram: single write port, one async read port, one registered read port. Instantiated for each bank.

Test Plan:
- Load T=3, W_hh[5*64+7]=0x00123; drive mce=1, msel=2, maddr=0x147 -> mdata_r=0x00123 in the same cycle. msel=4 -> mdata_r=3.
- start in IDLE -> ready=1; busy stays 0 for 4 cycles -> ready held high; busy=1 -> ready=0 next cycle; busy falls -> done=1 for exactly 1 cycle.
- Input bank {0xA5A5A5A5, 0x0F0F0F0F}; two separated i_en pulses -> idata=0xA5A5A5A5 after the first, held, then 0x0F0F0F0F after the second.
- Write msel=5, maddr={t=2,h=63}, mdata_w=0xF0000 -> rd_addr=2*64+63 yields 0xF0000 one cycle later. Write with t=16 -> err=1, no write.
- Third i_en with T=2 -> err=1, idata=0. ld_valid during RUN -> dropped, err stays 1.
- Assert reset=0 mid-RUN -> ready, done, idata, mdata_r all 0 asynchronously; FSM IDLE; previously written result still reads back.

Source files
------------

// File: rtl/rnn_pkg.sv
// rnn_pkg: shared bank encodings, sizes and FSM states for the RNN memory responder
package rnn_pkg;
    localparam int DW    = 20;
    localparam int HID   = 64;
    localparam int IN_W  = 32;
    localparam int T_MAX = 16;

    localparam logic [2:0] MSEL_WIH = 3'd0;
    localparam logic [2:0] MSEL_BIH = 3'd1;
    localparam logic [2:0] MSEL_WHH = 3'd2;
    localparam logic [2:0] MSEL_BHH = 3'd3;
    localparam logic [2:0] MSEL_T   = 3'd4;
    localparam logic [2:0] MSEL_OUT = 3'd5;
    localparam logic [2:0] LD_INPUT = 3'd6;

    typedef enum logic [1:0] {IDLE, ARM, RUN, FIN} state_t;
endpackage

// File: rtl/rnn_bank_ram.sv
// rnn_bank_ram: single-write RAM with one async read port and one registered read port
module rnn_bank_ram #(
    parameter int W = 20,
    parameter int D = 64,
    localparam int AW = $clog2(D)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata,
    input  logic [AW-1:0] qaddr,
    output logic [W-1:0]  qdata
);
    logic [W-1:0] mem [D];
    logic [W-1:0] qdata_q, qdata_d;

    // storage is never cleared so results survive a reset
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    // registered port lookup
    always_comb qdata_d = mem[qaddr];

    // registered read port output, zeroed by reset
    always_ff @(posedge clk or negedge reset)
        if (!reset) qdata_q <= '0;
        else        qdata_q <= qdata_d;

    assign rdata = mem[raddr];
    assign qdata = qdata_q;
endmodule

// File: rtl/rnn_mem_responder.sv
// rnn_mem_responder: environment-side memory/input responder for the RNN core.
// Optional RNN_RESP_STATS_EN adds per-bank access counters on stat_bus.
module rnn_mem_responder #(
    parameter int DW    = rnn_pkg::DW,
    parameter int HID   = rnn_pkg::HID,
    parameter int IN_W  = rnn_pkg::IN_W,
    parameter int T_MAX = rnn_pkg::T_MAX
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            busy,
    output logic            ready,
    input  logic            i_en,
    output logic [IN_W-1:0] idata,
    input  logic            mce,
    input  logic [2:0]      msel,
    input  logic [16:0]     maddr,
    output logic [DW-1:0]   mdata_r,
    input  logic [DW-1:0]   mdata_w,
    input  logic            ld_valid,
    input  logic [2:0]      ld_sel,
    input  logic [16:0]     ld_addr,
    input  logic [31:0]     ld_data,
    input  logic            start,
    output logic            done,
    output logic            err,
    input  logic [16:0]     rd_addr,
    output logic [DW-1:0]   rd_data
`ifdef RNN_RESP_STATS_EN
    ,
    output logic [111:0]    stat_bus
`endif
);
    import rnn_pkg::*;

    localparam int A_H   = $clog2(HID);
    localparam int A_T   = $clog2(T_MAX);
    localparam int A_WIH = $clog2(HID * IN_W);
    localparam int A_WHH = $clog2(HID * HID);
    localparam int A_R   = A_H + A_T;
    localparam int IPW   = A_T + 1;
    localparam int TW    = 17 - A_H;
    localparam logic [16:0] N_WIH = 17'(HID * IN_W);
    localparam logic [16:0] N_WHH = 17'(HID * HID);
    localparam logic [16:0] N_H   = 17'(HID);
    localparam logic [16:0] N_T   = 17'(T_MAX);

    state_t          state_q, state_d;
    logic [DW-1:0]   t_len_q, t_len_d;
    logic [IPW-1:0]  ip_q, ip_d;
    logic [IN_W-1:0] idata_q, idata_d;
    logic [DW-1:0]   mdata_q, mdata_d;
    logic            err_q, err_d;

    logic [DW-1:0]   wih_r, bih_r, whh_r, bhh_r;
    logic [IN_W-1:0] in_r;
    logic [DW-1:0]   wih_q_unused, bih_q_unused, whh_q_unused, bhh_q_unused, out_r_unused;
    logic [IN_W-1:0] in_q_unused;
    logic            rd_addr_unused;

    logic ld_ok, ld_hit, ld_err, arm_entry;
    logic out_t_bad, we_out, m_err, in_bad;

    assign rd_addr_unused = ^rd_addr[16:A_R];

    // loader acceptance, core write legality and input-pointer bounds
    always_comb begin
        arm_entry = state_q == IDLE && start;
        ld_ok     = ld_valid && state_q == IDLE;
        ld_hit    = (ld_sel == MSEL_WIH && ld_addr < N_WIH) ||
                    (ld_sel == MSEL_BIH && ld_addr < N_H)   ||
                    (ld_sel == MSEL_WHH && ld_addr < N_WHH) ||
                    (ld_sel == MSEL_BHH && ld_addr < N_H)   ||
                    (ld_sel == MSEL_T)                      ||
                    (ld_sel == LD_INPUT && ld_addr < N_T);
        ld_err    = ld_valid && !(ld_ok && ld_hit);
        out_t_bad = maddr[16:A_H] >= TW'(T_MAX);
        we_out    = mce && msel == MSEL_OUT && !out_t_bad;
        m_err     = mce && ((msel == MSEL_OUT && out_t_bad) || msel > MSEL_OUT);
        in_bad    = DW'(ip_q) >= t_len_q || ip_q >= IPW'(T_MAX);
    end

    rnn_bank_ram #(.W(DW), .D(HID * IN_W)) u_wih (
        .clk(clk), .reset(reset), .we(ld_ok && ld_hit && ld_sel == MSEL_WIH),
        .waddr(ld_addr[A_WIH-1:0]), .wdata(ld_data[DW-1:0]),
        .raddr(maddr[A_WIH-1:0]), .rdata(wih_r),
        .qaddr(maddr[A_WIH-1:0]), .qdata(wih_q_unused)
    );

    rnn_bank_ram #(.W(DW), .D(HID)) u_bih (
        .clk(clk), .reset(reset), .we(ld_ok && ld_hit && ld_sel == MSEL_BIH),
        .waddr(ld_addr[A_H-1:0]), .wdata(ld_data[DW-1:0]),
        .raddr(maddr[A_H-1:0]), .rdata(bih_r),
        .qaddr(maddr[A_H-1:0]), .qdata(bih_q_unused)
    );

    rnn_bank_ram #(.W(DW), .D(HID * HID)) u_whh (
        .clk(clk), .reset(reset), .we(ld_ok && ld_hit && ld_sel == MSEL_WHH),
        .waddr(ld_addr[A_WHH-1:0]), .wdata(ld_data[DW-1:0]),
        .raddr(maddr[A_WHH-1:0]), .rdata(whh_r),
        .qaddr(maddr[A_WHH-1:0]), .qdata(whh_q_unused)
    );

    rnn_bank_ram #(.W(DW), .D(HID)) u_bhh (
        .clk(clk), .reset(reset), .we(ld_ok && ld_hit && ld_sel == MSEL_BHH),
        .waddr(ld_addr[A_H-1:0]), .wdata(ld_data[DW-1:0]),
        .raddr(maddr[A_H-1:0]), .rdata(bhh_r),
        .qaddr(maddr[A_H-1:0]), .qdata(bhh_q_unused)
    );

    rnn_bank_ram #(.W(IN_W), .D(T_MAX)) u_in (
        .clk(clk), .reset(reset), .we(ld_ok && ld_hit && ld_sel == LD_INPUT),
        .waddr(ld_addr[A_T-1:0]), .wdata(ld_data[IN_W-1:0]),
        .raddr(ip_q[A_T-1:0]), .rdata(in_r),
        .qaddr(ip_q[A_T-1:0]), .qdata(in_q_unused)
    );

    rnn_bank_ram #(.W(DW), .D(T_MAX * HID)) u_out (
        .clk(clk), .reset(reset), .we(we_out),
        .waddr(maddr[A_R-1:0]), .wdata(mdata_w),
        .raddr(maddr[A_R-1:0]), .rdata(out_r_unused),
        .qaddr(rd_addr[A_R-1:0]), .qdata(rd_data)
    );

    // handshake FSM plus the datapath next-state values
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? ARM : IDLE;
            ARM:     state_d = busy ? RUN : ARM;
            RUN:     state_d = busy ? RUN : FIN;
            default: state_d = IDLE;
        endcase
        t_len_d = (ld_ok && ld_hit && ld_sel == MSEL_T) ? ld_data[DW-1:0] : t_len_q;
        ip_d    = arm_entry ? '0 : (i_en && !in_bad) ? ip_q + 1'b1 : ip_q;
        idata_d = i_en ? (in_bad ? '0 : in_r) : idata_q;
        mdata_d = !(mce && msel <= MSEL_T) ? mdata_q :
                  msel == MSEL_WIH ? wih_r :
                  msel == MSEL_BIH ? bih_r :
                  msel == MSEL_WHH ? whh_r :
                  msel == MSEL_BHH ? bhh_r : t_len_q;
        err_d   = err_q || (start && state_q != IDLE) || ld_err || m_err || (i_en && in_bad);
    end

    // control and datapath registers
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q <= IDLE;
            t_len_q <= '0;
            ip_q    <= '0;
            idata_q <= '0;
            mdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            t_len_q <= t_len_d;
            ip_q    <= ip_d;
            idata_q <= idata_d;
            mdata_q <= mdata_d;
            err_q   <= err_d;
        end

    assign ready   = state_q == ARM;
    assign done    = state_q == FIN;
    assign err     = err_q;
    assign idata   = idata_q;
    assign mdata_r = mdata_d;

`ifdef RNN_RESP_STATS_EN
    logic [15:0] cnt_q [7];
    logic [15:0] cnt_d [7];

    // saturating access counters, slot 6 counts input requests
    always_comb begin
        stat_bus = '0;
        for (int b = 0; b < 7; b++) begin
            cnt_d[b] = arm_entry ? '0 :
                       ((b < 6 ? (mce && msel == 3'(b)) : i_en) && cnt_q[b] != 16'hFFFF) ? cnt_q[b] + 16'd1 : cnt_q[b];
            stat_bus[16*b +: 16] = cnt_q[b];
        end
    end

    // counter registers
    always_ff @(posedge clk or negedge reset)
        if (!reset) for (int b = 0; b < 7; b++) cnt_q[b] <= '0;
        else        for (int b = 0; b < 7; b++) cnt_q[b] <= cnt_d[b];
`endif
endmodule

// File: tb/tb_rnn_mem_responder.sv
// tb_rnn_mem_responder: directed self-checking bench for rnn_mem_responder
module tb_rnn_mem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        busy = 1'b0, i_en = 1'b0, mce = 1'b0, ld_valid = 1'b0, start = 1'b0;
    logic [2:0]  msel = '0, ld_sel = '0;
    logic [16:0] maddr = '0, ld_addr = '0, rd_addr = '0;
    logic [19:0] mdata_w = '0;
    logic [31:0] ld_data = '0;
    logic        ready, done, err;
    logic [31:0] idata;
    logic [19:0] mdata_r, rd_data;
    int          checks = 0;
    int          errors = 0;
`ifdef RNN_RESP_STATS_EN
    logic [111:0] stat_bus;
`endif

    rnn_mem_responder dut (
        .clk(clk), .reset(reset), .busy(busy), .ready(ready), .i_en(i_en), .idata(idata),
        .mce(mce), .msel(msel), .maddr(maddr), .mdata_r(mdata_r), .mdata_w(mdata_w),
        .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .done(done), .err(err), .rd_addr(rd_addr), .rd_data(rd_data)
`ifdef RNN_RESP_STATS_EN
        , .stat_bus(stat_bus)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input logic [2:0] s, input logic [16:0] a, input logic [31:0] d);
        ld_valid = 1'b1; ld_sel = s; ld_addr = a; ld_data = d;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%h exp=0", ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%h exp=0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%h exp=0", err); end
        checks++; if (idata !== 32'h0) begin errors++; $display("FAIL reset_idata got=%h exp=0", idata); end
        checks++; if (mdata_r !== 20'h0) begin errors++; $display("FAIL reset_mdata_r got=%h exp=0", mdata_r); end
        checks++; if (rd_data !== 20'h0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        tick(); tick();
        @(negedge clk) reset = 1'b1;
    endtask

    task automatic test_read();
        ld(3'd4, 17'd0, 32'd3);
        ld(3'd2, 17'd327, 32'h00123);
        ld(3'd0, 17'd2047, 32'hABCDE);
        ld(3'd1, 17'd0, 32'h0AAAA);
        ld(3'd3, 17'd63, 32'h54321);
        ld(3'd6, 17'd0, 32'hA5A5A5A5);
        ld(3'd6, 17'd1, 32'h0F0F0F0F);
        mce = 1'b1; msel = 3'd2; maddr = 17'h147; #1;
        checks++; if (mdata_r !== 20'h00123) begin errors++; $display("FAIL read_whh got=%h exp=00123", mdata_r); end
        msel = 3'd0; maddr = 17'h7FF; #1;
        checks++; if (mdata_r !== 20'hABCDE) begin errors++; $display("FAIL read_wih_top got=%h exp=abcde", mdata_r); end
        msel = 3'd3; maddr = 17'd63; #1;
        checks++; if (mdata_r !== 20'h54321) begin errors++; $display("FAIL read_bhh_top got=%h exp=54321", mdata_r); end
        msel = 3'd4; maddr = 17'h1ABCD; #1;
        checks++; if (mdata_r !== 20'd3) begin errors++; $display("FAIL read_t got=%h exp=3", mdata_r); end
        tick();
        mce = 1'b0; msel = 3'd2; maddr = 17'h147; #1;
        checks++; if (mdata_r !== 20'd3) begin errors++; $display("FAIL read_hold got=%h exp=3", mdata_r); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL read_err got=%h exp=0", err); end
        ld(3'd4, 17'd0, 32'd2);
    endtask

    task automatic test_start_arm();
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL arm_ready got=%h exp=1", ready); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (ready !== 1'b1) begin errors++; $display("FAIL arm_hold%0d got=%h exp=1", i, ready); end
        end
        busy = 1'b1; tick();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL run_ready got=%h exp=0", ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL run_done got=%h exp=0", done); end
    endtask

    task automatic test_inputs();
        i_en = 1'b1; tick(); i_en = 1'b0;
        checks++; if (idata !== 32'hA5A5A5A5) begin errors++; $display("FAIL input0 got=%h exp=a5a5a5a5", idata); end
        tick(); tick();
        checks++; if (idata !== 32'hA5A5A5A5) begin errors++; $display("FAIL input0_hold got=%h exp=a5a5a5a5", idata); end
        i_en = 1'b1; tick(); i_en = 1'b0;
        checks++; if (idata !== 32'h0F0F0F0F) begin errors++; $display("FAIL input1 got=%h exp=0f0f0f0f", idata); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL input_err_clean got=%h exp=0", err); end
        i_en = 1'b1; tick(); i_en = 1'b0;
        checks++; if (idata !== 32'h0) begin errors++; $display("FAIL input_overrun_data got=%h exp=0", idata); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL input_overrun_err got=%h exp=1", err); end
    endtask

    task automatic test_result_write();
        mce = 1'b1; msel = 3'd5;
        maddr = {11'd2, 6'd63};  mdata_w = 20'hF0000; tick();
        maddr = {11'd0, 6'd0};   mdata_w = 20'h11111; tick();
        maddr = {11'd15, 6'd0};  mdata_w = 20'h12345; tick();
        maddr = {11'd16, 6'd0};  mdata_w = 20'h55555; tick();
        mce = 1'b0;
        rd_addr = 17'd191; tick();
        checks++; if (rd_data !== 20'hF0000) begin errors++; $display("FAIL result_t2h63 got=%h exp=f0000", rd_data); end
        rd_addr = 17'd0; tick();
        checks++; if (rd_data !== 20'h11111) begin errors++; $display("FAIL result_t16_dropped got=%h exp=11111", rd_data); end
        rd_addr = 17'd960; tick();
        checks++; if (rd_data !== 20'h12345) begin errors++; $display("FAIL result_t15 got=%h exp=12345", rd_data); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL result_err got=%h exp=1", err); end
        ld(3'd1, 17'd0, 32'h77777);
        mce = 1'b1; msel = 3'd1; maddr = 17'd0; #1;
        checks++; if (mdata_r !== 20'h0AAAA) begin errors++; $display("FAIL ld_in_run_dropped got=%h exp=0aaaa", mdata_r); end
        mce = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ld_in_run_err got=%h exp=1", err); end
    endtask

    task automatic test_done();
        busy = 1'b0; tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_pulse got=%h exp=1", done); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_single got=%h exp=0", done); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL idle_ready got=%h exp=0", ready); end
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1; tick(); start = 1'b0;
        busy = 1'b1; tick();
        i_en = 1'b1; tick(); i_en = 1'b0;
        checks++; if (idata !== 32'hA5A5A5A5) begin errors++; $display("FAIL rerun_ip_reset got=%h exp=a5a5a5a5", idata); end
        mce = 1'b1; msel = 3'd4; tick(); mce = 1'b0; #1;
        checks++; if (mdata_r !== 20'd2) begin errors++; $display("FAIL rerun_t_hold got=%h exp=2", mdata_r); end
        @(negedge clk) reset = 1'b0;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got=%h exp=0", ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%h exp=0", done); end
        checks++; if (idata !== 32'h0) begin errors++; $display("FAIL midrst_idata got=%h exp=0", idata); end
        checks++; if (mdata_r !== 20'h0) begin errors++; $display("FAIL midrst_mdata_r got=%h exp=0", mdata_r); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_err got=%h exp=0", err); end
        checks++; if (rd_data !== 20'h0) begin errors++; $display("FAIL midrst_rd_data got=%h exp=0", rd_data); end
        busy = 1'b0;
        @(negedge clk) reset = 1'b1;
        rd_addr = 17'd191; tick();
        checks++; if (rd_data !== 20'hF0000) begin errors++; $display("FAIL result_kept got=%h exp=f0000", rd_data); end
        ld_valid = 1'b1; ld_sel = 3'd1; ld_addr = 17'd5; ld_data = 32'h33333; start = 1'b1;
        tick();
        ld_valid = 1'b0; start = 1'b0;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL ld_start_arm got=%h exp=1", ready); end
        mce = 1'b1; msel = 3'd1; maddr = 17'd5; #1;
        checks++; if (mdata_r !== 20'h33333) begin errors++; $display("FAIL ld_start_load got=%h exp=33333", mdata_r); end
        mce = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ld_start_err got=%h exp=0", err); end
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL start_in_arm_err got=%h exp=1", err); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL start_in_arm_ready got=%h exp=1", ready); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_start_arm();
        test_inputs();
        test_result_write();
        test_done();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
